// File: rtl/game_status_ctrl.sv
// Round/lives/level sequencer: READY banner, play, death and level-clear pauses, game over.
// Every output is registered and follows its triggering input by one clk.
module game_status_ctrl #(
  parameter int unsigned READY_FRAMES = 120,
  parameter int unsigned DEATH_FRAMES = 90,
  parameter int unsigned CLEAR_FRAMES = 120,
  parameter int unsigned INIT_LIVES   = 3,
  parameter int unsigned MAX_LEVEL    = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       pacman_caught,
  input  logic       dots_cleared,
  output logic [1:0] pacman_lifes,
  output logic       waiting,
  output logic [3:0] level,
  output logic       freeze,
  output logic       entity_reset,
  output logic       maze_reload,
  output logic       game_over
);

  typedef enum logic [2:0] {
    StIdle, StReady, StPlaying, StDying, StLevelClear, StGameOver
  } state_e;

  localparam logic [7:0] ReadyLast = 8'(READY_FRAMES - 1);
  localparam logic [7:0] DeathLast = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] ClearLast = 8'(CLEAR_FRAMES - 1);
  localparam logic [1:0] InitLives = 2'(INIT_LIVES);
  localparam logic [3:0] MaxLevel  = 4'(MAX_LEVEL);

  state_e     state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [1:0] lifes_d;
  logic [3:0] level_d;
  logic       entity_reset_d, maze_reload_d;

  always_comb begin
    state_d        = state_q;
    lifes_d        = pacman_lifes;
    level_d        = level;
    entity_reset_d = 1'b0;
    maze_reload_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_btn) begin
          state_d        = StReady;
          entity_reset_d = 1'b1;
          maze_reload_d  = 1'b1;
        end
      end
      StReady: begin
        if (frame_tick && frame_cnt_q == ReadyLast) state_d = StPlaying;
      end
      StPlaying: begin
        // A catch on the same cycle as the last dot still costs a life.
        if (pacman_caught)     state_d = StDying;
        else if (dots_cleared) state_d = StLevelClear;
      end
      StDying: begin
        if (frame_tick && frame_cnt_q == DeathLast) begin
          if (pacman_lifes == 2'd0) begin
            state_d = StGameOver;
          end else begin
            state_d        = StReady;
            lifes_d        = pacman_lifes - 2'd1;
            entity_reset_d = 1'b1;
          end
        end
      end
      StLevelClear: begin
        if (frame_tick && frame_cnt_q == ClearLast) begin
          state_d        = StReady;
          entity_reset_d = 1'b1;
          maze_reload_d  = 1'b1;
          if (level < MaxLevel) level_d = level + 4'd1;
        end
      end
      StGameOver: begin
        if (start_btn) begin
          state_d        = StReady;
          lifes_d        = InitLives;
          level_d        = 4'd1;
          entity_reset_d = 1'b1;
          maze_reload_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Entering a state restarts the count, so a coincident tick is not counted.
    if (state_d != state_q) frame_cnt_d = 8'd0;
    else if (frame_tick)    frame_cnt_d = frame_cnt_q + 8'd1;
    else                    frame_cnt_d = frame_cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      frame_cnt_q  <= 8'd0;
      pacman_lifes <= InitLives;
      level        <= 4'd1;
      waiting      <= 1'b0;
      freeze       <= 1'b1;
      entity_reset <= 1'b0;
      maze_reload  <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      pacman_lifes <= lifes_d;
      level        <= level_d;
      waiting      <= (state_d == StReady);
      freeze       <= (state_d != StPlaying);
      entity_reset <= entity_reset_d;
      maze_reload  <= maze_reload_d;
      game_over    <= (state_d == StGameOver);
    end
  end

endmodule

// File: tb/tb_game_status_ctrl.sv
// Scoreboard bench for game_status_ctrl: each driven cycle queues the expected output
// snapshot, which is popped and compared one clk later.
module tb_game_status_ctrl;

  localparam int ReadyN = 120;
  localparam int DeathN = 90;
  localparam int ClearN = 120;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0, start_btn = 1'b0, pacman_caught = 1'b0, dots_cleared = 1'b0;
  logic [1:0] pacman_lifes;
  logic [3:0] level;
  logic       waiting, freeze, entity_reset, maze_reload, game_over;

  game_status_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_tick   (frame_tick),
    .start_btn    (start_btn),
    .pacman_caught(pacman_caught),
    .dots_cleared (dots_cleared),
    .pacman_lifes (pacman_lifes),
    .waiting      (waiting),
    .level        (level),
    .freeze       (freeze),
    .entity_reset (entity_reset),
    .maze_reload  (maze_reload),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [1:0] lives;
    logic [3:0] lvl;
    logic       w, f, g, er, mr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_lives, exp_lvl;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input int lives, input int lvl,
                              input bit w, input bit f, input bit g, input bit er, input bit mr);
    exp_t e;
    e.tag = tag; e.lives = 2'(lives); e.lvl = 4'(lvl);
    e.w = w; e.f = f; e.g = g; e.er = er; e.mr = mr;
    return e;
  endfunction

  task automatic compare_out();
    exp_t e;
    check_eq("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq({e.tag, ".lives"}, 32'(pacman_lifes), 32'(e.lives));
      check_eq({e.tag, ".level"}, 32'(level), 32'(e.lvl));
      check_eq({e.tag, ".waiting"}, 32'(waiting), 32'(e.w));
      check_eq({e.tag, ".freeze"}, 32'(freeze), 32'(e.f));
      check_eq({e.tag, ".game_over"}, 32'(game_over), 32'(e.g));
      check_eq({e.tag, ".entity_reset"}, 32'(entity_reset), 32'(e.er));
      check_eq({e.tag, ".maze_reload"}, 32'(maze_reload), 32'(e.mr));
    end
  endtask

  // Drive one cycle of stimulus, queue what the outputs must be after the edge, then compare.
  task automatic fire(input bit st, input bit ca, input bit dc, input bit ft, input exp_t e);
    start_btn = st; pacman_caught = ca; dots_cleared = dc; frame_tick = ft;
    sb.push_back(e);
    @(posedge clk); #1;
    start_btn = 0; pacman_caught = 0; dots_cleared = 0; frame_tick = 0;
    compare_out();
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Sit out a READY banner: still waiting after N-1 ticks, playing on tick N.
  task automatic finish_ready(input string tag);
    tick_n(ReadyN - 1);
    fire(0, 0, 0, 0, mk({tag, "_ready_end"}, exp_lives, exp_lvl, 1, 1, 0, 0, 0));
    fire(0, 0, 0, 1, mk({tag, "_play"}, exp_lives, exp_lvl, 0, 0, 0, 0, 0));
  endtask

  task automatic die(input string tag, input bit both);
    fire(0, 1, both, 0, mk({tag, "_dying"}, exp_lives, exp_lvl, 0, 1, 0, 0, 0));
    tick_n(DeathN - 1);
    fire(0, 0, 0, 0, mk({tag, "_dying_end"}, exp_lives, exp_lvl, 0, 1, 0, 0, 0));
    if (exp_lives == 0) begin
      fire(0, 0, 0, 1, mk({tag, "_gameover"}, 0, exp_lvl, 0, 1, 1, 0, 0));
    end else begin
      exp_lives--;
      fire(0, 0, 0, 1, mk({tag, "_respawn"}, exp_lives, exp_lvl, 1, 1, 0, 1, 0));
      fire(0, 0, 0, 0, mk({tag, "_respawn_nx"}, exp_lives, exp_lvl, 1, 1, 0, 0, 0));
    end
  endtask

  initial begin
    exp_lives = 3; exp_lvl = 1;

    // 1: reset state, held and after release.
    repeat (3) @(posedge clk);
    #1;
    sb.push_back(mk("reset", 3, 1, 0, 1, 0, 0, 0));
    compare_out();
    reset_n = 1'b1;
    fire(0, 0, 0, 0, mk("idle", 3, 1, 0, 1, 0, 0, 0));
    fire(0, 1, 1, 1, mk("idle_ign", 3, 1, 0, 1, 0, 0, 0));

    // 2: start with a coincident frame_tick, which must not shorten READY.
    fire(1, 0, 0, 1, mk("start", 3, 1, 1, 1, 0, 1, 1));
    fire(0, 0, 0, 0, mk("start_nx", 3, 1, 1, 1, 0, 0, 0));
    finish_ready("t2");
    fire(1, 0, 0, 1, mk("play_ign_start", 3, 1, 0, 0, 0, 0, 0));

    // 3: one death from three lives; catches ignored during READY.
    die("t3", 0);
    fire(0, 1, 1, 0, mk("ready_ign", exp_lives, exp_lvl, 1, 1, 0, 0, 0));
    finish_ready("t3");

    // 4: burn the remaining lives down to game over, then restart.
    die("t4a", 0); finish_ready("t4a");
    die("t4b", 0); finish_ready("t4b");
    die("t4c", 0);
    fire(0, 1, 1, 1, mk("go_ign", 0, 1, 0, 1, 1, 0, 0));
    exp_lives = 3; exp_lvl = 1;
    fire(1, 0, 0, 0, mk("restart", 3, 1, 1, 1, 0, 1, 1));
    finish_ready("t4r");

    // 5: caught and cleared together means death, level kept, no reload.
    die("t5", 1);
    finish_ready("t5");

    // 6: clear 15 levels; level tops out at 15.
    for (int i = 0; i < 15; i++) begin
      fire(0, 0, 1, 0, mk("clear", exp_lives, exp_lvl, 0, 1, 0, 0, 0));
      tick_n(ClearN - 1);
      fire(0, 0, 0, 0, mk("clear_end", exp_lives, exp_lvl, 0, 1, 0, 0, 0));
      if (exp_lvl < 15) exp_lvl++;
      fire(0, 0, 0, 1, mk("next_level", exp_lives, exp_lvl, 1, 1, 0, 1, 1));
      fire(0, 0, 0, 0, mk("next_level_nx", exp_lives, exp_lvl, 1, 1, 0, 0, 0));
      finish_ready("t6");
    end
    check_eq("level_sat", 32'(level), 32'd15);

    // Reset mid-DYING: immediate IDLE, no pulses during or after.
    fire(0, 1, 0, 0, mk("t6_dying", exp_lives, 15, 0, 1, 0, 0, 0));
    tick_n(10);
    #2 reset_n = 1'b0;
    #1;
    sb.push_back(mk("async_rst", 3, 1, 0, 1, 0, 0, 0));
    compare_out();
    fire(1, 0, 0, 1, mk("in_rst", 3, 1, 0, 1, 0, 0, 0));
    reset_n = 1'b1;
    fire(0, 0, 0, 0, mk("rst_rel", 3, 1, 0, 1, 0, 0, 0));
    fire(0, 0, 0, 1, mk("rst_rel2", 3, 1, 0, 1, 0, 0, 0));
    fire(1, 0, 0, 0, mk("post_rst_start", 3, 1, 1, 1, 0, 1, 1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
